// File: rtl/dram_lat_pkg.sv
// Shared widths, FIFO entry layout and sticky error bit positions for the
// DRAM latency monitor.
package dram_lat_pkg;

  localparam int unsigned DEF_ID_W  = 16;
  localparam int unsigned DEF_TS_W  = 32;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_SUM_W = 48;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_ORPH = 1;
  localparam int unsigned ERR_IDMM = 2;

  // Entry fields are sized to the default widths; narrower instances
  // store zero-extended values and truncate on readout.
  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [DEF_TS_W-1:0] ts;
    logic                tag;
  } lat_entry_t;

endpackage

// File: rtl/dram_lat_monitor_if.sv
// AXI4 AR/R/AW/B handshake subset observed by the latency monitor.
interface dram_lat_monitor_if
  import dram_lat_pkg::*;
#(
  parameter int unsigned ID_W = DEF_ID_W
) ();

  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] arid;
  logic            rvalid;
  logic            rready;
  logic            rlast;
  logic [ID_W-1:0] rid;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] awid;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;

  modport master (
    output arvalid, arid, rready, awvalid, awid, bready,
    input  arready, rvalid, rlast, rid, awready, bvalid, bid
  );

  modport slave (
    input  arvalid, arid, rready, awvalid, awid, bready,
    output arready, rvalid, rlast, rid, awready, bvalid, bid
  );

  // Passive tap: sees every signal, drives none.
  modport mon (
    input arvalid, arready, arid, rvalid, rready, rlast, rid,
          awvalid, awready, awid, bvalid, bready, bid
  );

endinterface

// File: rtl/lat_track.sv
// One direction of the latency monitor: request FIFO, completion pairing,
// latency subtraction and the statistics/error registers.
module lat_track
  import dram_lat_pkg::*;
#(
  parameter int unsigned ID_W  = DEF_ID_W,
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TS_W-1:0]  ts_i,
  input  logic             req_i,
  input  logic [ID_W-1:0]  req_id_i,
  input  logic             req_tag_i,
  input  logic             done_i,
  input  logic [ID_W-1:0]  done_id_i,
  input  logic             clear_i,
  output logic [31:0]      count_o,
  output logic [SUM_W-1:0] sum_o,
  output logic [TS_W-1:0]  min_o,
  output logic [TS_W-1:0]  max_o,
  output logic [TS_W-1:0]  last_o,
  output logic [2:0]       err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  lat_entry_t       mem_q [DEPTH];
  lat_entry_t       head;
  lat_entry_t       entry_in;
  logic [AW:0]      wp_q, rp_q;
  logic             empty, full;
  logic             pop, push, orphan, ovf, id_mm, flush, upd;
  logic [TS_W-1:0]  lat_d, lat_q;
  logic             pend_q;
  logic [31:0]      count_q;
  logic [SUM_W-1:0] sum_q, sum_sat;
  logic [SUM_W:0]   sum_ext;
  logic [TS_W-1:0]  min_q, max_q, last_q;
  logic [2:0]       err_q, err_d;

  always_comb begin
    head     = mem_q[rp_q[AW-1:0]];
    empty    = (wp_q == rp_q);
    full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop      = done_i && !empty;
    orphan   = done_i && empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = req_i && (!full || pop);
    ovf      = req_i && full && !pop;
    id_mm    = pop && (ID_W'(head.id) != done_id_i);
    flush    = clear_i && err_q[ERR_OVF];
    lat_d    = ts_i - TS_W'(head.ts);
    upd      = pend_q && !err_q[ERR_OVF];
    sum_ext  = {1'b0, sum_q} + (SUM_W+1)'(lat_q);
    sum_sat  = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    entry_in = '{id: DEF_ID_W'(req_id_i), ts: DEF_TS_W'(ts_i), tag: req_tag_i};
    err_d           = err_q;
    err_d[ERR_OVF]  = err_q[ERR_OVF]  | ovf;
    err_d[ERR_ORPH] = err_q[ERR_ORPH] | orphan;
    err_d[ERR_IDMM] = err_q[ERR_IDMM] | id_mm;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      pend_q  <= 1'b0;
      lat_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      last_q  <= '0;
      err_q   <= '0;
    end else begin
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + (AW+1)'(1);
        if (pop)  rp_q <= rp_q + (AW+1)'(1);
      end

      pend_q <= pop && head.tag && !flush;
      if (pop) lat_q <= lat_d;

      if (clear_i) begin
        count_q <= '0;
        sum_q   <= '0;
        min_q   <= '1;
        max_q   <= '0;
        last_q  <= '0;
        err_q   <= '0;
      end else begin
        err_q <= err_d;
        if (upd) begin
          if (count_q != '1) count_q <= count_q + 32'd1;
          sum_q  <= sum_sat;
          last_q <= lat_q;
          if (lat_q < min_q) min_q <= lat_q;
          if (lat_q > max_q) max_q <= lat_q;
        end
      end
    end
  end

  assign count_o = count_q;
  assign sum_o   = sum_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign last_o  = last_q;
  assign err_o   = err_q;

endmodule

// File: rtl/dram_lat_monitor.sv
// Passive AXI4 read/write latency monitor: free-running timestamp plus one
// lat_track per direction (AR->RLAST, AW->B).
module dram_lat_monitor
  import dram_lat_pkg::*;
#(
  parameter int unsigned ID_W  = DEF_ID_W,
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  dram_lat_monitor_if.mon     bus,
  input  logic                mon_en_i,
  input  logic                mon_clear_i,
  output logic [31:0]         rd_count_o,
  output logic [31:0]         wr_count_o,
  output logic [SUM_W-1:0]    rd_sum_o,
  output logic [SUM_W-1:0]    wr_sum_o,
  output logic [TS_W-1:0]     rd_min_o,
  output logic [TS_W-1:0]     wr_min_o,
  output logic [TS_W-1:0]     rd_max_o,
  output logic [TS_W-1:0]     wr_max_o,
  output logic [TS_W-1:0]     rd_last_o,
  output logic [TS_W-1:0]     wr_last_o,
  output logic [2:0]          rd_err_o,
  output logic [2:0]          wr_err_o
);

  logic [TS_W-1:0] ts_q;
  logic            ar_req, r_done, aw_req, b_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  always_comb begin
    ar_req = bus.arvalid && bus.arready;
    r_done = bus.rvalid && bus.rready && bus.rlast;
    aw_req = bus.awvalid && bus.awready;
    b_done = bus.bvalid && bus.bready;
  end

  lat_track #(
    .ID_W  (ID_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) u_rd (
    .clk       (clk),
    .rst_n     (rst_n),
    .ts_i      (ts_q),
    .req_i     (ar_req),
    .req_id_i  (bus.arid),
    .req_tag_i (mon_en_i),
    .done_i    (r_done),
    .done_id_i (bus.rid),
    .clear_i   (mon_clear_i),
    .count_o   (rd_count_o),
    .sum_o     (rd_sum_o),
    .min_o     (rd_min_o),
    .max_o     (rd_max_o),
    .last_o    (rd_last_o),
    .err_o     (rd_err_o)
  );

  lat_track #(
    .ID_W  (ID_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .ts_i      (ts_q),
    .req_i     (aw_req),
    .req_id_i  (bus.awid),
    .req_tag_i (mon_en_i),
    .done_i    (b_done),
    .done_id_i (bus.bid),
    .clear_i   (mon_clear_i),
    .count_o   (wr_count_o),
    .sum_o     (wr_sum_o),
    .min_o     (wr_min_o),
    .max_o     (wr_max_o),
    .last_o    (wr_last_o),
    .err_o     (wr_err_o)
  );

endmodule

// File: tb/tb_dram_lat_monitor.sv
// Directed scoreboard bench for dram_lat_monitor, built with an 8-bit
// timestamp so the wrap case is reachable in a few hundred cycles.
module tb_dram_lat_monitor;

  localparam int unsigned TW = 8;
  localparam int unsigned SW = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_en = 1'b1;
  logic mon_clear = 1'b0;

  logic [31:0]   rd_count, wr_count;
  logic [SW-1:0] rd_sum, wr_sum;
  logic [TW-1:0] rd_min, wr_min, rd_max, wr_max, rd_last, wr_last;
  logic [2:0]    rd_err, wr_err;

  dram_lat_monitor_if #(.ID_W(16)) bus ();

  dram_lat_monitor #(.ID_W(16), .TS_W(TW), .DEPTH(16), .SUM_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mon_en_i    (mon_en),
    .mon_clear_i (mon_clear),
    .rd_count_o  (rd_count),
    .wr_count_o  (wr_count),
    .rd_sum_o    (rd_sum),
    .wr_sum_o    (wr_sum),
    .rd_min_o    (rd_min),
    .wr_min_o    (wr_min),
    .rd_max_o    (rd_max),
    .wr_max_o    (wr_max),
    .rd_last_o   (rd_last),
    .wr_last_o   (wr_last),
    .rd_err_o    (rd_err),
    .wr_err_o    (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            wr;
    logic [31:0]   cnt;
    logic [SW-1:0] sum;
    logic [TW-1:0] mn;
    logic [TW-1:0] mx;
    logic [TW-1:0] lst;
    logic [2:0]    err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned ts_m = 0;   // timestamp value sampled at the next active edge

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  function automatic void exp_push(string nm, bit wr, logic [31:0] c, logic [SW-1:0] s,
                                   logic [TW-1:0] mn, logic [TW-1:0] mx,
                                   logic [TW-1:0] ls, logic [2:0] er);
    exp_t e;
    e.name = nm; e.wr = wr; e.cnt = c; e.sum = s;
    e.mn = mn; e.mx = mx; e.lst = ls; e.err = er;
    sb.push_back(e);
  endfunction

  // Monitor: drains the scoreboard just after each falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.wr) begin
          chk({e.name, ".rd_count"}, 64'(rd_count), 64'(e.cnt));
          chk({e.name, ".rd_sum"},   64'(rd_sum),   64'(e.sum));
          chk({e.name, ".rd_min"},   64'(rd_min),   64'(e.mn));
          chk({e.name, ".rd_max"},   64'(rd_max),   64'(e.mx));
          chk({e.name, ".rd_last"},  64'(rd_last),  64'(e.lst));
          chk({e.name, ".rd_err"},   64'(rd_err),   64'(e.err));
        end else begin
          chk({e.name, ".wr_count"}, 64'(wr_count), 64'(e.cnt));
          chk({e.name, ".wr_sum"},   64'(wr_sum),   64'(e.sum));
          chk({e.name, ".wr_min"},   64'(wr_min),   64'(e.mn));
          chk({e.name, ".wr_max"},   64'(wr_max),   64'(e.mx));
          chk({e.name, ".wr_last"},  64'(wr_last),  64'(e.lst));
          chk({e.name, ".wr_err"},   64'(wr_err),   64'(e.err));
        end
      end
    end
  end

  // One clock of stimulus. Valids idle high with ready low, so only a real
  // handshake may register as an event.
  task automatic step(input logic ar, input logic [15:0] arid,
                      input logic rv, input logic rl, input logic [15:0] rid,
                      input logic aw, input logic [15:0] awid,
                      input logic b,  input logic [15:0] bid, input logic clr);
    bus.arvalid = 1'b1; bus.arready = ar; bus.arid = arid;
    bus.rvalid  = 1'b1; bus.rready  = rv; bus.rlast = rv ? rl : 1'b1; bus.rid = rid;
    bus.awvalid = 1'b1; bus.awready = aw; bus.awid = awid;
    bus.bvalid  = 1'b1; bus.bready  = b;  bus.bid = bid;
    mon_clear   = clr;
    @(negedge clk);
    ts_m = (ts_m + 1) % (1 << TW);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(0, 16'd0, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 0);
  endtask
  task automatic clear_step();
    step(0, 16'd0, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 1);
  endtask
  task automatic rd_req(input logic [15:0] id);
    step(1, id, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 0);
  endtask
  task automatic rd_done(input logic [15:0] id);
    step(0, 16'd0, 1, 1, id, 0, 16'd0, 0, 16'd0, 0);
  endtask
  task automatic wr_req(input logic [15:0] id);
    step(0, 16'd0, 0, 0, 16'd0, 1, id, 0, 16'd0, 0);
  endtask
  task automatic wr_done(input logic [15:0] id);
    step(0, 16'd0, 0, 0, 16'd0, 0, 16'd0, 1, id, 0);
  endtask
  task automatic wr_xact(input logic [15:0] id, input int unsigned lat);
    wr_req(id);
    idle(lat - 1);
    wr_done(id);
  endtask

  initial begin : stimulus
    bus.arvalid = 0; bus.arready = 0; bus.arid = '0;
    bus.rvalid = 0; bus.rready = 0; bus.rlast = 0; bus.rid = '0;
    bus.awvalid = 0; bus.awready = 0; bus.awid = '0;
    bus.bvalid = 0; bus.bready = 0; bus.bid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ts_m  = 0;
    exp_push("reset", 0, 0, 0, 8'hFF, 0, 0, 3'b000);
    exp_push("reset", 1, 0, 0, 8'hFF, 0, 0, 3'b000);

    // Read issued at ts=10, RLAST at ts=52, one non-last beat in between.
    idle(10);
    rd_req(16'd0);
    idle(20);
    step(0, 16'd0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 0);
    idle(20);
    rd_done(16'd0);
    idle(1);
    exp_push("rd_single", 0, 1, 42, 42, 42, 42, 3'b000);

    // Three writes: latencies 20, 5, 30.
    wr_xact(16'd3, 20);
    wr_xact(16'd3, 5);
    wr_xact(16'd3, 30);
    idle(1);
    exp_push("wr_three", 1, 3, 55, 5, 30, 30, 3'b000);

    // 17 reads into a 16-deep FIFO: overflow, later pops are not counted.
    repeat (17) rd_req(16'd7);
    repeat (3) rd_done(16'd7);
    idle(1);
    exp_push("rd_ovf", 0, 1, 42, 42, 42, 42, 3'b001);
    clear_step();
    exp_push("rd_ovf_clr", 0, 0, 0, 8'hFF, 0, 0, 3'b000);
    exp_push("wr_clr", 1, 0, 0, 8'hFF, 0, 0, 3'b000);
    rd_done(16'd7);
    idle(1);
    exp_push("rd_flushed", 0, 0, 0, 8'hFF, 0, 0, 3'b010);
    clear_step();

    // Write orphans.
    wr_done(16'd9);
    idle(1);
    exp_push("wr_orphan", 1, 0, 0, 8'hFF, 0, 0, 3'b010);
    clear_step();
    step(0, 16'd0, 0, 0, 16'd0, 1, 16'd4, 1, 16'd4, 0);
    idle(6);
    wr_done(16'd4);
    idle(1);
    exp_push("wr_orph_push", 1, 1, 7, 7, 7, 7, 3'b010);
    clear_step();

    // Timestamp wrap: request at 2^TW-5, completion 15 cycles later.
    while (ts_m != (1 << TW) - 5) idle(1);
    rd_req(16'd1);
    idle(14);
    rd_done(16'd1);
    idle(1);
    exp_push("rd_wrap", 0, 1, 15, 15, 15, 15, 3'b000);
    clear_step();

    // Untagged then tagged read; tagged one completes with a wrong id.
    mon_en = 1'b0;
    rd_req(16'd1);
    mon_en = 1'b1;
    rd_req(16'd2);
    mon_en = 1'b0;
    idle(4);
    rd_done(16'd1);
    idle(2);
    rd_done(16'd5);
    idle(1);
    mon_en = 1'b1;
    exp_push("rd_tag_idmm", 0, 1, 8, 8, 8, 8, 3'b100);
    clear_step();

    // Both directions in parallel, with push and pop in one cycle.
    step(1, 16'd0, 0, 0, 16'd0, 1, 16'd0, 0, 16'd0, 0);
    idle(3);
    step(1, 16'd0, 1, 1, 16'd0, 1, 16'd0, 1, 16'd0, 0);
    idle(1);
    step(0, 16'd0, 1, 1, 16'd0, 0, 16'd0, 1, 16'd0, 0);
    idle(1);
    exp_push("rd_parallel", 0, 2, 6, 2, 4, 2, 3'b000);
    exp_push("wr_parallel", 1, 2, 6, 2, 4, 2, 3'b000);

    // Clear coinciding with a stat update: clear wins.
    clear_step();
    rd_req(16'd0);
    idle(2);
    rd_done(16'd0);
    clear_step();
    idle(1);
    exp_push("rd_clr_wins", 0, 0, 0, 8'hFF, 0, 0, 3'b000);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
